// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Buffers a single valid/ready stream of register writes in a FIFO and issues
// up to N_WRITE of the oldest entries per cycle onto the register file write
// ports. Program order is preserved: port 0 always carries the oldest entry,
// and a group never contains two entries aimed at the same address.

module regfile_write_scheduler #(
    parameter int N_BIT_DATA    = 32,
    parameter int N_BIT_ADDRESS = 32,
    parameter int N_WRITE       = 4,
    parameter int DEPTH         = 8
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [N_BIT_ADDRESS-1:0]                    in_address,
    input  logic [N_BIT_DATA-1:0]                       in_data,
    input  logic                                        hold,
    output logic [N_WRITE-1:0]                          write,
    output logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0]       address_write,
    output logic [N_WRITE-1:0][N_BIT_DATA-1:0]          data_in,
    output logic [$clog2(DEPTH+1)-1:0]                  level,
    output logic                                        empty
);

    // Pointer, occupancy and group-count widths. The pointer mask keeps the
    // modulo-DEPTH wrap correct even for a single-entry FIFO.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(N_WRITE + 1);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    logic [N_BIT_ADDRESS-1:0] addr_mem [DEPTH];
    logic [N_BIT_DATA-1:0]    data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;

    logic push;

    logic [PTR_W-1:0]         head_idx     [N_WRITE];
    logic [N_BIT_ADDRESS-1:0] head_addr    [N_WRITE];
    logic [N_BIT_DATA-1:0]    head_data    [N_WRITE];
    logic [N_WRITE-1:0]       head_present;
    logic [N_WRITE-1:0]       conflict;

    logic [CNT_W-1:0] dispatch_count;
    logic             group_open;

    // Acceptance depends only on the registered occupancy, so a full FIFO
    // refuses a request even when entries leave in the same cycle.
    assign level    = level_q;
    assign empty    = (level_q == '0);
    assign in_ready = (level_q < LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;

    // Look at the N_WRITE oldest slots starting at the read pointer and note
    // which of them actually hold a queued entry.
    always_comb begin
        for (int i = 0; i < N_WRITE; i++) begin
            head_idx[i]     = (rd_ptr + PTR_W'(i)) & PTR_MASK;
            head_addr[i]    = addr_mem[head_idx[i]];
            head_data[i]    = data_mem[head_idx[i]];
            head_present[i] = (LVL_W'(i) < level_q);
        end
    end

    // Flag every head slot whose address repeats one held by an older slot;
    // such an entry must wait and lead the next group instead.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < N_WRITE; i++) begin
            for (int j = 0; j < N_WRITE; j++) begin
                if ((j < i) && (head_addr[j] == head_addr[i])) begin
                    conflict[i] = 1'b1;
                end
            end
        end
    end

    // Grow the group oldest-first and stop at the first missing or
    // conflicting entry; hold or an empty FIFO yields an empty group.
    always_comb begin
        dispatch_count = '0;
        group_open     = !(hold || empty);
        for (int i = 0; i < N_WRITE; i++) begin
            if (group_open) begin
                if (!head_present[i] || conflict[i]) begin
                    group_open = 1'b0;
                end else begin
                    dispatch_count = CNT_W'(i + 1);
                end
            end
        end
    end

    // Storage array is written on every accepted push; it needs no reset
    // because occupancy alone decides which slots are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_address;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; reset drops everything still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + PTR_W'(1)) & PTR_MASK;
            end
            rd_ptr  <= (rd_ptr + PTR_W'(dispatch_count)) & PTR_MASK;
            level_q <= level_q + LVL_W'(push) - LVL_W'(dispatch_count);
        end
    end

    // Registered write ports: the group lands in age order on ports 0..k-1
    // for exactly one cycle, idle ports are driven fully to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            write         <= '0;
            address_write <= '0;
            data_in       <= '0;
        end else begin
            for (int i = 0; i < N_WRITE; i++) begin
                if (CNT_W'(i) < dispatch_count) begin
                    write[i]         <= 1'b1;
                    address_write[i] <= head_addr[i];
                    data_in[i]       <= head_data[i];
                end else begin
                    write[i]         <= 1'b0;
                    address_write[i] <= '0;
                    data_in[i]       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler
// Directed scenarios followed by a randomized phase, every cycle compared
// against a queue-based reference model of the write scheduler.

module tb_regfile_write_scheduler;

    localparam int NB_D  = 32;
    localparam int NB_A  = 32;
    localparam int NW    = 4;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         in_valid;
    logic                         in_ready;
    logic [NB_A-1:0]              in_address;
    logic [NB_D-1:0]              in_data;
    logic                         hold;
    logic [NW-1:0]                write;
    logic [NW-1:0][NB_A-1:0]      address_write;
    logic [NW-1:0][NB_D-1:0]      data_in;
    logic [LVL_W-1:0]             level;
    logic                         empty;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NB_A-1:0] a;
        logic [NB_D-1:0] d;
    } entry_t;

    entry_t                  model_q[$];
    logic [NW-1:0]           exp_write;
    logic [NW-1:0][NB_A-1:0] exp_addr;
    logic [NW-1:0][NB_D-1:0] exp_data;
    logic [NB_D-1:0]         rf [logic [NB_A-1:0]];

    regfile_write_scheduler #(
        .N_BIT_DATA   (NB_D),
        .N_BIT_ADDRESS(NB_A),
        .N_WRITE      (NW),
        .DEPTH        (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_address   (in_address),
        .in_data      (in_data),
        .hold         (hold),
        .write        (write),
        .address_write(address_write),
        .data_in      (data_in),
        .level        (level),
        .empty        (empty)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Reference model: one clock edge. The queue holds entries oldest first;
    // the group is the longest prefix (up to NW) with no repeated address.
    task automatic modelStep(input logic r, input logic v, input logic h,
                             input logic [NB_A-1:0] a, input logic [NB_D-1:0] d);
        int  k;
        bit  room;
        bit  seen_dup;
        exp_write = '0;
        exp_addr  = '0;
        exp_data  = '0;
        if (r) begin
            model_q.delete();
            return;
        end
        room = (model_q.size() < DEPTH);
        k = 0;
        if (!h) begin
            for (int n = 0; n < NW && n < model_q.size(); n++) begin
                seen_dup = 0;
                for (int m = 0; m < n; m++) begin
                    if (model_q[m].a == model_q[n].a) seen_dup = 1;
                end
                if (seen_dup) break;
                k++;
            end
        end
        for (int n = 0; n < k; n++) begin
            exp_write[n] = 1'b1;
            exp_addr[n]  = model_q[0].a;
            exp_data[n]  = model_q[0].d;
            void'(model_q.pop_front());
        end
        if (v && room) model_q.push_back('{a: a, d: d});
    endtask

    // Compare all DUT outputs with the model after an edge, then apply the
    // observed port writes to the shadow register file in port order.
    task automatic checkOutput();
        logic             exp_ready;
        logic [LVL_W-1:0] exp_level;
        exp_ready = (model_q.size() < DEPTH);
        exp_level = LVL_W'(model_q.size());
        checks++;
        assert (in_ready === exp_ready) else begin
            failures++;
            $error("[TB] FAIL in_ready observed=%0b expected=%0b", in_ready, exp_ready);
        end
        checks++;
        assert (level === exp_level) else begin
            failures++;
            $error("[TB] FAIL level observed=%0d expected=%0d", level, exp_level);
        end
        checks++;
        assert (empty === (exp_level == 0)) else begin
            failures++;
            $error("[TB] FAIL empty observed=%0b expected=%0b", empty, (exp_level == 0));
        end
        checks++;
        assert (write === exp_write) else begin
            failures++;
            $error("[TB] FAIL write observed=%b expected=%b", write, exp_write);
        end
        checks++;
        assert (address_write === exp_addr) else begin
            failures++;
            $error("[TB] FAIL address_write observed=%h expected=%h", address_write, exp_addr);
        end
        checks++;
        assert (data_in === exp_data) else begin
            failures++;
            $error("[TB] FAIL data_in observed=%h expected=%h", data_in, exp_data);
        end
        for (int j = 0; j < NW; j++) begin
            if (write[j] === 1'b1) rf[address_write[j]] = data_in[j];
        end
    endtask

    // Directed comparison against a constant written from the scenario text.
    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check #1 later.
    task automatic applyStimulus(input logic r, input logic v, input logic h,
                                 input logic [NB_A-1:0] a, input logic [NB_D-1:0] d);
        reset      = r;
        in_valid   = v;
        hold       = h;
        in_address = a;
        in_data    = d;
        @(posedge clock);
        modelStep(r, v, h, a, d);
        #1;
        checkOutput();
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        hold       = 1'b0;
        in_address = '0;
        in_data    = '0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h11, 32'h22);
        checkValue("reset_write", 64'(write), 64'h0);
        checkValue("reset_in_ready", 64'(in_ready), 64'h1);

        // Scenario 1: streamed single pushes, one-cycle latency to port 0
        applyStimulus(0, 1, 0, 3, 32'hA);
        checkValue("s1_no_bypass", 64'(write), 64'h0);
        applyStimulus(0, 1, 0, 5, 32'hB);
        checkValue("s1_port0_addr3", 64'(address_write[0]), 64'd3);
        applyStimulus(0, 1, 0, 7, 32'hC);
        applyStimulus(0, 1, 0, 9, 32'hD);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s1_port0_data_d", 64'(data_in[0]), 64'hD);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s1_empty", 64'(empty), 64'h1);

        // Scenario 2: six entries under hold, then two groups
        for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 1, NB_A'(i), NB_D'(100 + i));
        checkValue("s2_level6", 64'(level), 64'd6);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s2_group1_write", 64'(write), 64'hF);
        checkValue("s2_group1_port3", 64'(address_write[3]), 64'd4);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s2_group2_write", 64'(write), 64'h3);
        checkValue("s2_group2_port1", 64'(address_write[1]), 64'd6);
        applyStimulus(0, 0, 0, 0, 0);

        // Scenario 3: same-address split, final value is the third push
        applyStimulus(0, 1, 1, 4, 32'hC1);
        applyStimulus(0, 1, 1, 8, 32'hC2);
        applyStimulus(0, 1, 1, 4, 32'hC3);
        applyStimulus(0, 1, 1, 2, 32'hC4);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s3_group1_write", 64'(write), 64'h3);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s3_group2_port0", 64'(address_write[0]), 64'd4);
        checkValue("s3_group2_port1", 64'(address_write[1]), 64'd2);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s3_rf_addr4", 64'(rf[32'd4]), 64'hC3);

        // Scenario 4: fill, rejected ninth request, wrap-around refill
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, NB_A'(10 + i), NB_D'(200 + i));
        checkValue("s4_full_ready", 64'(in_ready), 64'h0);
        applyStimulus(0, 1, 1, 99, 32'h999);
        checkValue("s4_full_level", 64'(level), 64'd8);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("s4_ready_after_drop", 64'(in_ready), 64'h1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, NB_A'(30 + i), NB_D'(300 + i));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

        // Scenario 5: continuous stream with distinct addresses
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, NB_A'(40 + i), NB_D'(400 + i));
            checkValue("s5_level_le1", 64'(level <= 1), 64'h1);
            checkValue("s5_in_ready", 64'(in_ready), 64'h1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Scenario 6: reset right after the first dispatch
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, NB_A'(50 + i), NB_D'(500 + i));
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkValue("s6_write_cleared", 64'(write), 64'h0);
        checkValue("s6_level_cleared", 64'(level), 64'd0);
        checkValue("s6_empty", 64'(empty), 64'h1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic with a narrow address range to force conflicts
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 3) == 0),
                          NB_A'($urandom_range(0, 7)),
                          NB_D'($urandom));
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
